// File: rtl/nv_nvdla_csb_slave.sv
// CSB register slave: ID/STATUS/CFG0-3/OP_EN behind a one-cycle registered
// request/response handshake, with write and error counters.
module nv_nvdla_csb_slave #(
    parameter logic [21:0] BASE_ADDR = 22'h000000,
    parameter logic [31:0] ID_VALUE  = 32'h0001_0000
) (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rst,
    input  logic         csb2slv_req_pvld,
    output logic         csb2slv_req_prdy,
    input  logic [62:0]  csb2slv_req_pd,
    output logic         slv2csb_resp_valid,
    output logic [33:0]  slv2csb_resp_pd,
    output logic [127:0] reg2dp_cfg,
    output logic         reg2dp_op_en,
    input  logic         dp2reg_done
);

    logic [21:0] req_addr;
    logic [31:0] req_wdat;
    logic        req_write;
    logic        req_nposted;
    logic [3:0]  req_wrbe;
    logic        unused_req_fields;

    assign req_addr          = csb2slv_req_pd[21:0];
    assign req_wdat          = csb2slv_req_pd[53:22];
    assign req_write         = csb2slv_req_pd[54];
    assign req_nposted       = csb2slv_req_pd[55];
    assign req_wrbe          = csb2slv_req_pd[60:57];
    assign unused_req_fields = ^{csb2slv_req_pd[62:61], csb2slv_req_pd[56]};

    logic             prdy_q, prdy_d;
    logic [3:0][31:0] cfg_q, cfg_d;
    logic             op_en_q, op_en_d;
    logic             busy_q, busy_d;
    logic [15:0]      wr_cnt_q, wr_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             resp_valid_q, resp_valid_d;
    logic [33:0]      resp_pd_q, resp_pd_d;

    logic        accept;
    logic        hit;
    logic [2:0]  offset;
    logic [1:0]  cfg_idx;
    logic        is_err;
    logic [31:0] rdata;

    always_comb begin
        accept  = csb2slv_req_pvld & prdy_q;
        hit     = (req_addr[21:3] == BASE_ADDR[21:3]);
        offset  = req_addr[2:0];
        cfg_idx = offset[1:0] - 2'd2;
        is_err  = !hit || (offset == 3'd7) || (req_write && (offset <= 3'd1));

        // Read data reflects state before any update made by this request.
        case (offset)
            3'd0:                      rdata = ID_VALUE;
            3'd1:                      rdata = {err_cnt_q, wr_cnt_q};
            3'd2, 3'd3, 3'd4, 3'd5:    rdata = cfg_q[cfg_idx];
            3'd6:                      rdata = {31'b0, busy_q};
            default:                   rdata = 32'h0;
        endcase
    end

    always_comb begin
        prdy_d       = 1'b1;
        cfg_d        = cfg_q;
        op_en_d      = 1'b0;
        busy_d       = dp2reg_done ? 1'b0 : busy_q;
        wr_cnt_d     = wr_cnt_q;
        err_cnt_d    = err_cnt_q;
        resp_valid_d = 1'b0;
        resp_pd_d    = resp_pd_q;

        if (accept) begin
            if (is_err) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end else if (req_write) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
                if (offset >= 3'd2 && offset <= 3'd5) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_wrbe[b]) cfg_d[cfg_idx][b*8 +: 8] = req_wdat[b*8 +: 8];
                    end
                end else if (offset == 3'd6 && req_wdat[0]) begin
                    // A start request overrides a coincident completion.
                    op_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            if (!req_write || req_nposted) begin
                resp_valid_d = 1'b1;
                resp_pd_d    = {req_write, is_err, (is_err || req_write) ? 32'h0 : rdata};
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            prdy_q       <= 1'b0;
            cfg_q        <= '0;
            op_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            wr_cnt_q     <= 16'h0;
            err_cnt_q    <= 16'h0;
            resp_valid_q <= 1'b0;
            resp_pd_q    <= 34'h0;
        end else begin
            prdy_q       <= prdy_d;
            cfg_q        <= cfg_d;
            op_en_q      <= op_en_d;
            busy_q       <= busy_d;
            wr_cnt_q     <= wr_cnt_d;
            err_cnt_q    <= err_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_pd_q    <= resp_pd_d;
        end
    end

    assign csb2slv_req_prdy   = prdy_q;
    assign slv2csb_resp_valid = resp_valid_q;
    assign slv2csb_resp_pd    = resp_pd_q;
    assign reg2dp_cfg         = cfg_q;
    assign reg2dp_op_en       = op_en_q;

endmodule

// File: tb/tb_nv_nvdla_csb_slave.sv
// Scoreboard bench for nv_nvdla_csb_slave: expected responses are queued as
// requests are driven and compared by a negedge monitor as they emerge.
module tb_nv_nvdla_csb_slave;

    localparam logic [21:0] BASE = 22'h001230;
    localparam logic [31:0] ID   = 32'h0001_0000;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         pvld = 1'b0;
    logic [62:0]  pd   = '0;
    logic         done = 1'b0;
    logic         prdy;
    logic         rvalid;
    logic [33:0]  rpd;
    logic [127:0] cfg;
    logic         op_en;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [33:0] exp_q[$];
    logic [31:0] cfg_m[4];
    logic [15:0] wr_m;
    logic [15:0] err_m;

    nv_nvdla_csb_slave #(.BASE_ADDR(BASE), .ID_VALUE(ID)) dut (
        .nvdla_core_clk     (clk),
        .nvdla_core_rst     (rst),
        .csb2slv_req_pvld   (pvld),
        .csb2slv_req_prdy   (prdy),
        .csb2slv_req_pd     (pd),
        .slv2csb_resp_valid (rvalid),
        .slv2csb_resp_pd    (rpd),
        .reg2dp_cfg         (cfg),
        .reg2dp_op_en       (op_en),
        .dp2reg_done        (done)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected: got %h, required no response", rpd);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if (rpd !== e) begin
                    n_fail++;
                    $display("FAIL resp_pd: got %h, required %h", rpd, e);
                end
            end
        end
    end

    function automatic logic [62:0] mk_pd(input logic [21:0] addr, input logic [31:0] wdat,
                                          input logic wr, input logic np, input logic [3:0] be);
        logic [2:0] r;
        r = 3'($urandom);
        return {r[2:1], be, r[0], np, wr, wdat, addr};
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wdat,
                                             input logic [3:0] be);
        logic [31:0] v;
        v = old;
        if (be[0]) v[7:0]   = wdat[7:0];
        if (be[1]) v[15:8]  = wdat[15:8];
        if (be[2]) v[23:16] = wdat[23:16];
        if (be[3]) v[31:24] = wdat[31:24];
        return v;
    endfunction

    task automatic issue(input logic [21:0] addr, input logic [31:0] wdat, input logic wr,
                         input logic np, input logic [3:0] be, input logic [33:0] exp);
        @(negedge clk);
        pvld = 1'b1;
        pd   = mk_pd(addr, wdat, wr, np, be);
        if (!wr || np) exp_q.push_back(exp);
        @(negedge clk);
        pvld = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks += 5;
        if (prdy !== 1'b0)   begin n_fail++; $display("FAIL rst_prdy: got %b, required 0", prdy); end
        if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b, required 0", rvalid); end
        if (rpd !== 34'h0)   begin n_fail++; $display("FAIL rst_rpd: got %h, required 0", rpd); end
        if (cfg !== 128'h0)  begin n_fail++; $display("FAIL rst_cfg: got %h, required 0", cfg); end
        if (op_en !== 1'b0)  begin n_fail++; $display("FAIL rst_op_en: got %b, required 0", op_en); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (prdy !== 1'b0) begin n_fail++; $display("FAIL prdy_first_cycle: got %b, required 0", prdy); end
        @(negedge clk);
        n_checks++;
        if (prdy !== 1'b1) begin n_fail++; $display("FAIL prdy_after_release: got %b, required 1", prdy); end
        issue(BASE, 32'h0, 1'b0, 1'b0, 4'hF, {2'b00, 32'h0001_0000});
        settle();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL id_missing: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_posted_err();
        issue(BASE, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'hF, 34'h0);
        err_m++;
        issue(BASE + 22'd1, 32'h0, 1'b0, 1'b0, 4'hF, {2'b00, 32'h0001_0000});
        issue(BASE + 22'd1, 32'h1234_5678, 1'b1, 1'b1, 4'hF, {2'b11, 32'h0});
        err_m++;
        issue(BASE + 22'd1, 32'h0, 1'b0, 1'b0, 4'hF, {2'b00, err_m, wr_m});
        settle();
        n_checks += 2;
        if (cfg !== 128'h0) begin n_fail++; $display("FAIL err_cfg: got %h, required 0", cfg); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL err_missing: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_cfg_write();
        issue(BASE + 22'd3, 32'hA5A5_1234, 1'b1, 1'b1, 4'b0101, {2'b10, 32'h0});
        cfg_m[1] = merge_be(cfg_m[1], 32'hA5A5_1234, 4'b0101);
        wr_m++;
        issue(BASE + 22'd3, 32'h0, 1'b0, 1'b0, 4'hF, {2'b00, 32'h00A5_0034});
        n_checks++;
        if (cfg[63:32] !== 32'h00A5_0034) begin n_fail++; $display("FAIL cfg1_out: got %h, required 00a50034", cfg[63:32]); end
        issue(BASE + 22'd4, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'b0000, {2'b10, 32'h0});
        wr_m++;
        issue(BASE + 22'd4, 32'h0, 1'b0, 1'b0, 4'hF, {2'b00, 32'h0});
        issue(BASE + 22'd1, 32'h0, 1'b0, 1'b0, 4'hF, {2'b00, err_m, wr_m});
        settle();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL cfg_missing: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_random_cfg();
        for (int i = 0; i < 12; i++) begin
            int          off;
            int          rd;
            logic [31:0] w;
            logic [3:0]  be;
            logic        np;
            off = $urandom_range(2, 5);
            rd  = $urandom_range(2, 5);
            w   = $urandom;
            be  = 4'($urandom_range(0, 15));
            np  = 1'($urandom_range(0, 1));
            issue(BASE + 22'(off), w, 1'b1, np, be, {2'b10, 32'h0});
            cfg_m[off-2] = merge_be(cfg_m[off-2], w, be);
            wr_m++;
            issue(BASE + 22'(rd), 32'h0, 1'b0, 1'b0, 4'hF, {2'b00, cfg_m[rd-2]});
        end
        settle();
        n_checks += 2;
        if (cfg !== {cfg_m[3], cfg_m[2], cfg_m[1], cfg_m[0]}) begin
            n_fail++;
            $display("FAIL rand_cfg_out: got %h, required %h", cfg, {cfg_m[3], cfg_m[2], cfg_m[1], cfg_m[0]});
        end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_missing: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_op_en();
        @(negedge clk);
        pvld = 1'b1;
        pd   = mk_pd(BASE + 22'd6, 32'h1, 1'b1, 1'b1, 4'hF);
        done = 1'b1;
        exp_q.push_back({2'b10, 32'h0});
        wr_m++;
        @(negedge clk);
        pvld = 1'b0;
        done = 1'b0;
        n_checks++;
        if (op_en !== 1'b1) begin n_fail++; $display("FAIL op_en_pulse: got %b, required 1", op_en); end
        @(negedge clk);
        n_checks++;
        if (op_en !== 1'b0) begin n_fail++; $display("FAIL op_en_width: got %b, required 0", op_en); end
        issue(BASE + 22'd6, 32'h0, 1'b0, 1'b0, 4'hF, {2'b00, 32'h1});
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        issue(BASE + 22'd6, 32'h0, 1'b0, 1'b0, 4'hF, {2'b00, 32'h0});
        issue(BASE + 22'd6, 32'hFFFF_FFFE, 1'b1, 1'b1, 4'hF, {2'b10, 32'h0});
        wr_m++;
        n_checks++;
        if (op_en !== 1'b0) begin n_fail++; $display("FAIL op_en_zero_write: got %b, required 0", op_en); end
        issue(BASE + 22'd6, 32'h0, 1'b0, 1'b0, 4'hF, {2'b00, 32'h0});
        settle();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL op_missing: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        pvld = 1'b1;
        pd   = mk_pd(BASE + 22'd8, 32'h0, 1'b0, 1'b0, 4'hF);
        exp_q.push_back({2'b01, 32'h0});
        @(negedge clk);
        pd = mk_pd(BASE + 22'd7, 32'h0, 1'b0, 1'b0, 4'hF);
        exp_q.push_back({2'b01, 32'h0});
        n_checks++;
        if (rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %b, required 1", rvalid); end
        @(negedge clk);
        pvld = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %b, required 1", rvalid); end
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b, required 0", rvalid); end
        err_m += 16'd2;
        issue(BASE + 22'd1, 32'h0, 1'b0, 1'b0, 4'hF, {2'b00, err_m, wr_m});
        settle();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        pvld = 1'b1;
        pd   = mk_pd(BASE + 22'd2, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'hF);
        @(posedge clk);
        #1;
        pvld = 1'b0;
        rst  = 1'b1;
        #1;
        n_checks += 5;
        if (rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid: got %b, required 0", rvalid); end
        if (rpd !== 34'h0)   begin n_fail++; $display("FAIL mid_rpd: got %h, required 0", rpd); end
        if (cfg !== 128'h0)  begin n_fail++; $display("FAIL mid_cfg: got %h, required 0", cfg); end
        if (op_en !== 1'b0)  begin n_fail++; $display("FAIL mid_op_en: got %b, required 0", op_en); end
        if (prdy !== 1'b0)   begin n_fail++; $display("FAIL mid_prdy: got %b, required 0", prdy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) cfg_m[k] = 32'h0;
        wr_m  = 16'h0;
        err_m = 16'h0;
        #1;
        n_checks++;
        if (prdy !== 1'b0) begin n_fail++; $display("FAIL mid_prdy_release: got %b, required 0", prdy); end
        settle();
        issue(BASE + 22'd2, 32'h0, 1'b0, 1'b0, 4'hF, {2'b00, 32'h0});
        issue(BASE + 22'd1, 32'h0, 1'b0, 1'b0, 4'hF, {2'b00, 32'h0});
        settle();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_missing: got %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 4; k++) cfg_m[k] = 32'h0;
        wr_m  = 16'h0;
        err_m = 16'h0;
        test_reset();
        test_posted_err();
        test_cfg_write();
        test_random_cfg();
        test_op_en();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_csb_slave.md
NV_NVDLA_CSB_SLAVE -- requirements
Module: nv_nvdla_csb_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 22'h000000, word-address window base; bits [21:3] used for decode.
REQ-002 SHALL have parameter ID_VALUE, default 32'h0001_0000, constant returned by the ID register.
REQ-003 SHALL have port nvdla_core_clk  input  1  single clock for all logic.
REQ-004 SHALL have port nvdla_core_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port csb2slv_req_pvld  input  1  request valid from csb master.
REQ-006 SHALL have port csb2slv_req_prdy  output  1  request ready.
REQ-007 SHALL have port csb2slv_req_pd  input  63  request packet: addr[21:0], wdat[53:22], write[54], nposted[55], srcpriv[56], wrbe[60:57], level[62:61].
REQ-008 SHALL have port slv2csb_resp_valid  output  1  response valid; no ready, consumer always accepts.
REQ-009 SHALL have port slv2csb_resp_pd  output  34  response: rdata[31:0], error[32], type[33] (0 read, 1 nposted write).
REQ-010 SHALL have port reg2dp_cfg  output  128  CFG0..CFG3 concatenated, CFG0 in [31:0].
REQ-011 SHALL have port reg2dp_op_en  output  1  one-cycle start pulse.
REQ-012 SHALL have port dp2reg_done  input  1  one-cycle completion pulse from datapath.

Function
REQ-013 SHALL accept a request in cycle T when csb2slv_req_pvld and csb2slv_req_prdy are both 1; at most one per cycle.
REQ-014 SHALL hold csb2slv_req_prdy 0 during reset and in the first cycle after release, then 1 permanently (registered ready flag).
REQ-015 SHALL decode hit when addr[21:3]==BASE_ADDR[21:3]; offset = addr[2:0].
REQ-016 SHALL map offsets: 0 ID (RO), 1 STATUS (RO) = {err_cnt[15:0], wr_cnt[15:0]}, 2-5 CFG0-CFG3 (RW), 6 OP_EN, 7 unmapped.
REQ-017 SHALL on CFG write update only bytes whose wrbe bit is 1; wrbe=4'b0000 leaves register unchanged without error.
REQ-018 SHALL on OP_EN write with wdat[0]=1 assert reg2dp_op_en in cycle T+1 only and set busy; wdat[0]=0 has no effect.
REQ-019 SHALL clear busy on dp2reg_done; if set (REQ-018) and dp2reg_done coincide, busy ends 1 (set wins).
REQ-020 SHALL return OP_EN read data {31'b0, busy}.
REQ-021 SHALL flag error for: address miss, offset 7, write to offset 0 or 1; errored writes change no state; errored reads return rdata 0.
REQ-022 SHALL produce a response for every accepted read and every accepted write with nposted=1; posted writes (nposted=0) produce none.
REQ-023 SHALL drive slv2csb_resp_valid in cycle T+1 (latency 1, registered) for one cycle, with resp_pd held stable while valid; back-to-back requests give back-to-back responses.
REQ-024 SHALL sample read data from register state before any update in cycle T; written values visible to requests accepted at T+1 or later.
REQ-025 SHALL increment wr_cnt on each accepted non-error write and err_cnt on each errored request (posted or not), both saturating at 16'hFFFF.
REQ-026 SHALL ignore srcpriv and level fields.

Reset
REQ-027 SHALL, on nvdla_core_rst=1, immediately and asynchronously clear: csb2slv_req_prdy, slv2csb_resp_valid, slv2csb_resp_pd, reg2dp_cfg, reg2dp_op_en, busy, wr_cnt, err_cnt (all 0).
REQ-028 SHALL drop any in-flight response when reset asserts mid-operation; no response emerges after release for requests accepted before reset.

Verification
REQ-029 Reset release, then read offset 0 at BASE_ADDR -> prdy 0 first cycle after release; response next cycle pd = {1'b0,1'b0,32'h0001_0000}.
REQ-030 Nposted write CFG1 wdat 32'hA5A5_1234 wrbe 4'b0101, then read CFG1 -> write resp type 1 error 0; read 32'h00A5_0034; reg2dp_cfg[63:32] = 32'h00A5_0034; STATUS wr_cnt 1.
REQ-031 Posted write to offset 0, then read STATUS -> no response for write; STATUS = 32'h0001_0000 (err_cnt 1, wr_cnt 0).
REQ-032 Write OP_EN wdat 1 with dp2reg_done pulsed same cycle, read OP_EN, pulse done, read OP_EN -> reg2dp_op_en high exactly 1 cycle; reads return 1 then 0.
REQ-033 Read addr BASE_ADDR+8 and offset 7 back-to-back -> two consecutive response cycles, each rdata 0 error 1.
REQ-034 Accept nposted write, assert reset the next cycle -> no resp_valid, all outputs 0, CFG unchanged from 0.
